fetch_ctrl_seq: RTL and testbench

- Instruction fetch and control sequencer that sits directly upstream of the datapath top (register file plus ALU).
- Keeps the PC and issues requests to instruction memory over a req/valid handshake.
- Latches each returned word and decodes it into the datapath control inputs: instruction, ALU_Control, op_B_sel and wEn.
- wEn is a single-cycle pulse per legal instruction. The block also keeps a retired-instruction count and halts on an all-zero word.

---
 rtl/fetch_ctrl_seq.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl_seq.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_seq.sv
// Instruction fetch and control sequencer: owns the PC, fetches over a req/valid
// handshake, and decodes OP/OP-IMM words into datapath control with a one-cycle wEn.
module fetch_ctrl_seq #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_rdata,
   input  logic                  imem_valid,
   input  logic                  stall,
   output logic [31:0]           instruction,
   output logic [5:0]            ALU_Control,
   output logic                  op_B_sel,
   output logic                  wEn,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  illegal,
   output logic                  halted,
   output logic [31:0]           retired
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state_r;
   logic        legal_s;
   logic        wen_s;
   logic        opb_s;
   logic [5:0]  alu_s;
   logic        capture_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;

   assign funct3_s  = imem_rdata[14:12];
   assign funct7_s  = imem_rdata[31:25];
   assign capture_s = imem_req & imem_valid;
   assign imem_addr = pc;

   // Decode the word on the read bus so it can be latched on the capture edge
   always_comb begin
      legal_s = 1'b0;
      opb_s   = 1'b0;
      alu_s   = 6'd0;
      case (imem_rdata[6:0])
         7'b0010011: begin
            legal_s = 1'b1;
            opb_s   = 1'b1;
            alu_s   = {2'b00, (funct3_s == 3'b101) & imem_rdata[30], funct3_s};
         end
         7'b0110011: begin
            opb_s = 1'b0;
            alu_s = {2'b00, imem_rdata[30], funct3_s};
            if (funct7_s == 7'b0000000) begin
               legal_s = 1'b1;
            end else if (funct7_s == 7'b0100000) begin
               legal_s = (funct3_s == 3'b000) | (funct3_s == 3'b101);
            end else begin
               legal_s = 1'b0;
            end
         end
         default: begin
            legal_s = 1'b0;
         end
      endcase
      wen_s = legal_s & (imem_rdata[11:7] != 5'd0);
   end

   // Sequencer FSM; every output is a register updated here
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         instruction <= 32'd0;
         ALU_Control <= 6'd0;
         op_B_sel    <= 1'b0;
         wEn         <= 1'b0;
         illegal     <= 1'b0;
         halted      <= 1'b0;
         retired     <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               state_r  <= FETCH;
               imem_req <= ~stall;
            end
            FETCH: begin
               if (capture_s) begin
                  instruction <= imem_rdata;
                  imem_req    <= 1'b0;
                  // An all-zero word parks the sequencer without touching the decode outputs
                  if (imem_rdata == 32'd0) begin
                     state_r <= HALT;
                     halted  <= 1'b1;
                  end else begin
                     state_r     <= EXEC;
                     ALU_Control <= alu_s;
                     op_B_sel    <= opb_s;
                     wEn         <= wen_s;
                     illegal     <= illegal | ~legal_s;
                  end
               end else begin
                  imem_req <= ~stall;
               end
            end
            EXEC: begin
               state_r  <= FETCH;
               wEn      <= 1'b0;
               pc       <= pc + PC_STEP;
               imem_req <= ~stall;
               if (wEn) begin
                  retired <= retired + 32'd1;
               end else begin
                  retired <= retired;
               end
            end
            HALT: begin
               imem_req <= 1'b0;
               wEn      <= 1'b0;
               halted   <= 1'b1;
            end
            default: begin
               state_r  <= IDLE;
               imem_req <= 1'b0;
               wEn      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl_seq.sv
// Bench for fetch_ctrl_seq: decode vector table, directed multi-cycle sequences and
// randomized memory timing checked against a cycle-level transaction model.
module tb_fetch_ctrl_seq;

   localparam int AW = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata;
   logic          imem_valid;
   logic          stall;
   logic [31:0]   instruction;
   logic [5:0]    ALU_Control;
   logic          op_B_sel;
   logic          wEn;
   logic [AW-1:0] pc;
   logic          illegal;
   logic          halted;
   logic [31:0]   retired;

   always #5 clock = ~clock;

   fetch_ctrl_seq #(.ADDR_WIDTH(AW), .RESET_PC(16'h0000)) dut (
      .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
      .instruction(instruction), .ALU_Control(ALU_Control), .op_B_sel(op_B_sel),
      .wEn(wEn), .pc(pc), .illegal(illegal), .halted(halted), .retired(retired)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [64];

   // reference model state (what the sequencer should be doing this cycle)
   bit          m_idle, m_exec, m_halt, m_req, m_wen, m_ill, m_dec_ok;
   logic [AW-1:0] m_pc;
   logic [31:0] m_ret, m_instr;
   logic [5:0]  m_alu;
   logic        m_opb;

   bit          cap_prev, stall_prev;
   logic [31:0] word_prev;
   int          wait_cnt, fixed_lat, wen_seen;
   bit          stall_rand, stall_ovr, noise;

   typedef struct {
      logic [31:0] word;
      logic [5:0]  alu;
      logic        opb;
      logic        wen;
      logic        ill;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int next_lat();
      if (fixed_lat >= 0) return fixed_lat;
      return int'($urandom_range(0, 3));
   endfunction

   function automatic void ref_decode(input logic [31:0] w, output bit legal,
                                      output logic [5:0] alu, output logic opb);
      int f3;
      int sub;
      f3    = int'(w[14:12]);
      sub   = w[30] ? 8 : 0;
      legal = 1'b0;
      alu   = 6'd0;
      opb   = 1'b0;
      if (w[6:0] == 7'h13) begin
         legal = 1'b1;
         opb   = 1'b1;
         alu   = 6'(f3 + ((f3 == 5) ? sub : 0));
      end else if (w[6:0] == 7'h33) begin
         legal = (w[31:25] == 7'h00) || (w[31:25] == 7'h20 && (f3 == 0 || f3 == 5));
         alu   = 6'(f3 + sub);
      end
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 4))
         0: w[6:0] = 7'h13;
         1: begin w[6:0] = 7'h33; w[31:25] = 7'h00; end
         2: begin w[6:0] = 7'h33; w[31:25] = 7'h20; end
         3: w[6:0] = 7'h33;
         default: w = w;
      endcase
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      if (w == 32'd0) w = 32'h0000_0013;
      return w;
   endfunction

   // Assert reset mid-cycle, confirm the asynchronous clear, hold across an edge, release.
   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_imem_req", imem_req, 0);
      check("rst_pc", pc, 0);
      check("rst_instruction", instruction, 0);
      check("rst_alu", ALU_Control, 0);
      check("rst_opb", op_B_sel, 0);
      check("rst_wEn", wEn, 0);
      check("rst_illegal", illegal, 0);
      check("rst_halted", halted, 0);
      check("rst_retired", retired, 0);
      imem_valid = 1'b1;
      imem_rdata = 32'h0010_0593;
      @(negedge clock);
      reset    = 1'b1;
      stall    = 1'b0;
      m_idle   = 1; m_exec = 0; m_halt = 0; m_req = 0; m_wen = 0; m_ill = 0; m_dec_ok = 1;
      m_pc     = '0; m_ret = 32'd0; m_instr = 32'd0; m_alu = 6'd0; m_opb = 1'b0;
      cap_prev = 0; stall_prev = 0; word_prev = 32'd0;
      wait_cnt = next_lat();
      wen_seen = 0;
   endtask

   // One clock: advance the model over the edge just taken, compare, then drive inputs.
   task automatic step();
      bit          legal;
      logic [5:0]  alu;
      logic        opb;
      @(negedge clock);
      if (m_idle) begin
         m_idle = 0; m_req = !stall_prev;
      end else if (m_halt) begin
         m_req = 0;
      end else if (m_exec) begin
         m_exec = 0; m_pc = m_pc + 16'd4;
         if (m_wen) m_ret = m_ret + 32'd1;
         m_wen = 0; m_req = !stall_prev;
      end else if (cap_prev) begin
         m_req   = 0;
         m_instr = word_prev;
         if (word_prev == 32'd0) begin
            m_halt = 1; m_dec_ok = 0;
         end else begin
            ref_decode(word_prev, legal, alu, opb);
            m_exec   = 1;
            m_wen    = legal && (word_prev[11:7] != 5'd0);
            m_dec_ok = legal;
            if (!legal) m_ill = 1;
            if (legal) begin m_alu = alu; m_opb = opb; end
         end
      end else begin
         m_req = !stall_prev;
      end

      check("pc", pc, m_pc);
      check("imem_addr", imem_addr, m_pc);
      check("imem_req", imem_req, m_req);
      check("wEn", wEn, m_exec && m_wen);
      check("halted", halted, m_halt);
      check("illegal", illegal, m_ill);
      check("retired", retired, m_ret);
      check("instruction", instruction, m_instr);
      if (m_dec_ok) begin
         check("ALU_Control", ALU_Control, m_alu);
         check("op_B_sel", op_B_sel, m_opb);
      end
      if (wEn) wen_seen++;

      stall = stall_ovr || (stall_rand && $urandom_range(0, 7) == 0);
      if (imem_req) begin
         if (wait_cnt == 0) begin
            imem_valid = 1'b1;
            imem_rdata = mem[imem_addr[7:2]];
            wait_cnt   = next_lat();
         end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom();
            wait_cnt--;
         end
      end else begin
         imem_valid = noise && ($urandom_range(0, 3) == 0);
         imem_rdata = $urandom();
      end
      cap_prev   = imem_req && imem_valid;
      word_prev  = imem_rdata;
      stall_prev = stall;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 64; i++) mem[i] = 32'd0;
   endtask

   initial begin
      int n;
      reset = 1'b1; stall = 1'b0; imem_valid = 1'b0; imem_rdata = 32'd0;
      fixed_lat = 0; stall_rand = 0; stall_ovr = 0; noise = 0;

      vecs[0]  = '{32'h0010_0593, 6'b000000, 1'b1, 1'b1, 1'b0}; // addi a1,zero,1
      vecs[1]  = '{32'h40E6_08B3, 6'b001000, 1'b0, 1'b1, 1'b0}; // sub a7,a2,a4
      vecs[2]  = '{32'h00F5_A533, 6'b000010, 1'b0, 1'b1, 1'b0}; // slt a0,a1,a5
      vecs[3]  = '{32'h00C5_C533, 6'b000100, 1'b0, 1'b1, 1'b0}; // xor
      vecs[4]  = '{32'h00C5_F533, 6'b000111, 1'b0, 1'b1, 1'b0}; // and
      vecs[5]  = '{32'h4035_D513, 6'b001101, 1'b1, 1'b1, 1'b0}; // srai
      vecs[6]  = '{32'h40C5_D533, 6'b001101, 1'b0, 1'b1, 1'b0}; // sra
      vecs[7]  = '{32'h00B5_0033, 6'b000000, 1'b0, 1'b0, 1'b0}; // add rd=x0
      vecs[8]  = '{32'h0000_007F, 6'b000000, 1'b0, 1'b0, 1'b1}; // bad opcode
      vecs[9]  = '{32'h02C5_8533, 6'b000000, 1'b0, 1'b0, 1'b1}; // funct7=0000001
      vecs[10] = '{32'h40C5_C533, 6'b000000, 1'b0, 1'b0, 1'b1}; // funct7=0100000, funct3=100

      // Decode table: one instruction per reset, zero-wait memory
      foreach (vecs[k]) begin
         clear_mem();
         mem[0] = vecs[k].word;
         do_reset();
         n = 0;
         while (!m_exec && n < 20) begin step(); n++; end
         check("tbl_exec_reached", m_exec, 1);
         check("tbl_wEn", wEn, vecs[k].wen);
         check("tbl_instruction", instruction, vecs[k].word);
         if (!vecs[k].ill) begin
            check("tbl_ALU_Control", ALU_Control, vecs[k].alu);
            check("tbl_op_B_sel", op_B_sel, vecs[k].opb);
         end
         step();
         check("tbl_wEn_drop", wEn, 0);
         check("tbl_pc", pc, 16'h0004);
         check("tbl_retired", retired, vecs[k].wen);
         check("tbl_illegal", illegal, vecs[k].ill);
      end

      // sub then slt back to back
      clear_mem();
      mem[0] = 32'h40E6_08B3; mem[1] = 32'h00F5_A533;
      do_reset();
      for (int i = 0; i < 8; i++) step();
      check("seq2_retired", retired, 2);
      check("seq2_wen_pulses", wen_seen, 2);
      check("seq2_halted", halted, 1);
      check("seq2_pc", pc, 16'h0008);

      // delayed valid plus a two-cycle stall mid-fetch
      clear_mem();
      mem[0] = 32'h0010_0593;
      fixed_lat = 3; noise = 1;
      do_reset();
      step(); step();
      stall_ovr = 1; step(); step();
      stall_ovr = 0;
      for (int i = 0; i < 12; i++) step();
      check("stall_wen_pulses", wen_seen, 1);
      check("stall_retired", retired, 1);
      check("stall_pc", pc, 16'h0004);
      check("stall_halted", halted, 1);
      noise = 0; fixed_lat = 0;

      // illegal word then rd=x0
      clear_mem();
      mem[0] = 32'h0000_007F; mem[1] = 32'h00B5_0033;
      do_reset();
      for (int i = 0; i < 12; i++) step();
      check("ill_illegal", illegal, 1);
      check("ill_retired", retired, 0);
      check("ill_pc", pc, 16'h0008);
      check("ill_wen_pulses", wen_seen, 0);

      // halt at 0x10, hold ten cycles, reset out of it
      clear_mem();
      for (int i = 0; i < 4; i++) mem[i] = 32'h0010_0593;
      do_reset();
      for (int i = 0; i < 14; i++) step();
      check("halt_halted", halted, 1);
      check("halt_retired", retired, 4);
      for (int i = 0; i < 10; i++) begin
         step();
         check("halt_pc_frozen", pc, 16'h0010);
         check("halt_req_low", imem_req, 0);
      end
      do_reset();
      step();
      check("halt_resume_req", imem_req, 1);
      check("halt_resume_halted", halted, 0);
      check("halt_resume_pc", pc, 16'h0000);

      // reset during a pending fetch; late valid must be ignored
      clear_mem();
      mem[0] = 32'h0010_0593;
      fixed_lat = 10;
      do_reset();
      step(); step(); step();
      check("pend_req_high", imem_req, 1);
      fixed_lat = 0;
      do_reset();
      step(); step(); step();
      check("pend_retired", retired, 1);
      check("pend_pc", pc, 16'h0004);

      // randomized program, memory latency, stall and stray valids
      for (int i = 0; i < 64; i++) mem[i] = rand_word();
      fixed_lat = -1; stall_rand = 1; noise = 1;
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < 700; i++) step();
         check("rand_wen_vs_retired", retired, wen_seen);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
